// File: rtl/ps2_key_event_queue_pkg.sv
// Shared types and constants for the PS/2 key event queue: parser states,
// scan-code constants and the packing of a queued key word.
package ps2_key_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_EXT       = 2'd1,
        S_BREAK     = 2'd2,
        S_EXT_BREAK = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;
    localparam logic [7:0] PS2_PAUSE        = 8'hE1;
    localparam logic [7:0] PS2_LSHIFT       = 8'h12;
    localparam logic [7:0] PS2_RSHIFT       = 8'h59;

    localparam int KEY_CODE_W = 8;
    localparam int KEY_ID_W   = KEY_CODE_W + 1;   // {extended, code}
    localparam int KEY_WORD_W = KEY_CODE_W + 2;   // {shift, extended, code}

    // Bytes the keyboard uses as fill/error markers; never a key of ours.
    function automatic logic is_junk_byte(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hFF) || (b == PS2_PAUSE);
    endfunction

endpackage

// File: rtl/ps2_key_event_queue_if.sv
// Bundle between the PS/2 byte source / LCD consumer (master) and the
// key event queue (slave). Signal names match the block's port list.
interface ps2_key_event_queue_if
    import ps2_key_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) ();
    // PS2_code is valid while PS2_code_ready is high; a new byte is marked by
    // the rising edge of PS2_code_ready. Key_pop_I removes the head entry in
    // the cycle it is high while Key_valid_O is high; no back-pressure exists.
    logic [7:0]            PS2_code;
    logic                  PS2_code_ready;
    logic                  Clear_I;
    logic                  Key_pop_I;
    logic                  Key_valid_O;
    logic [KEY_WORD_W-1:0] Key_data_O;
    logic [DEPTH_LOG2:0]   Key_count_O;
    logic                  Shift_O;
    logic                  Overflow_O;
    ps2_state_e            parser_state;

    modport master (
        output PS2_code, PS2_code_ready, Clear_I, Key_pop_I,
        input  Key_valid_O, Key_data_O, Key_count_O, Shift_O, Overflow_O,
        input  parser_state
    );

    modport slave (
        input  PS2_code, PS2_code_ready, Clear_I, Key_pop_I,
        output Key_valid_O, Key_data_O, Key_count_O, Shift_O, Overflow_O,
        output parser_state
    );
endinterface

// File: rtl/ps2_event_fifo.sv
// Synchronous show-ahead FIFO: head word is visible combinationally, reads
// zero when empty. Clear beats push; a push into a full FIFO without a pop
// is dropped and latches the sticky overflow flag.
module ps2_event_fifo #(
    parameter int W          = 10,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [W-1:0]        data_i,
    output logic [W-1:0]        data_o,
    output logic [DEPTH_LOG2:0] count_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                overflow_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [W-1:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  do_push, do_pop;

    assign full_o  = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty_o = (count_q == '0);

    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign do_pop  = pop_i && !empty_o && !clear_i;
    assign do_push = push_i && (!full_o || pop_i) && !clear_i;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (push_i && full_o && !pop_i) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= data_i;
    end

    assign data_o     = empty_o ? '0 : mem[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
endmodule

// File: rtl/ps2_key_event_queue.sv
// Turns the raw PS/2 scan byte stream into queued key presses: strips E0/F0
// prefixes and break codes, tracks shift and drops typematic repeats.
module ps2_key_event_queue
    import ps2_key_pkg::*;
#(
    parameter int DEPTH_LOG2      = 4,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic                  Clock_50,
    input  logic                  Reset,
    ps2_key_event_queue_if.slave  bus
);
    logic                buf_q;
    logic                strobe;
    ps2_state_e          state_q, state_d;
    logic                ev_make, ev_break, ev_ext;
    logic                lshift_q, lshift_d, rshift_q, rshift_d;
    logic                held_valid_q, held_valid_d;
    logic [KEY_ID_W-1:0] held_key_q, held_key_d;
    logic [KEY_ID_W-1:0] key_id;
    logic                is_lshift, is_rshift;
    logic                push;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                fifo_full, fifo_empty;

    assign strobe = bus.PS2_code_ready & ~buf_q;

    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            buf_q        <= 1'b0;
            state_q      <= S_IDLE;
            lshift_q     <= 1'b0;
            rshift_q     <= 1'b0;
            held_valid_q <= 1'b0;
            held_key_q   <= '0;
        end else begin
            buf_q        <= bus.PS2_code_ready;
            state_q      <= state_d;
            lshift_q     <= lshift_d;
            rshift_q     <= rshift_d;
            held_valid_q <= held_valid_d;
            held_key_q   <= held_key_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (strobe) begin
            if (is_junk_byte(bus.PS2_code)) begin
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.PS2_code == PS2_PREFIX_EXT)        state_d = S_EXT;
                        else if (bus.PS2_code == PS2_PREFIX_BREAK) state_d = S_BREAK;
                    end
                    S_EXT: begin
                        if (bus.PS2_code == PS2_PREFIX_BREAK) state_d = S_EXT_BREAK;
                        else                                  state_d = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        ev_make  = 1'b0;
        ev_break = 1'b0;
        ev_ext   = 1'b0;
        if (strobe && !is_junk_byte(bus.PS2_code)) begin
            case (state_q)
                S_IDLE: ev_make = (bus.PS2_code != PS2_PREFIX_EXT) &&
                                  (bus.PS2_code != PS2_PREFIX_BREAK);
                S_EXT: begin
                    ev_make = (bus.PS2_code != PS2_PREFIX_BREAK);
                    ev_ext  = 1'b1;
                end
                S_BREAK: ev_break = 1'b1;
                S_EXT_BREAK: begin
                    ev_break = 1'b1;
                    ev_ext   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign key_id    = {ev_ext, bus.PS2_code};
    assign is_lshift = !ev_ext && (bus.PS2_code == PS2_LSHIFT);
    assign is_rshift = !ev_ext && (bus.PS2_code == PS2_RSHIFT);

    // Shift keys only steer the shift bits; they never enter the queue or the
    // held-key register, so holding shift does not disturb repeat filtering.
    always_comb begin
        lshift_d     = lshift_q;
        rshift_d     = rshift_q;
        held_valid_d = held_valid_q;
        held_key_d   = held_key_q;
        push         = 1'b0;
        if (ev_make) begin
            if (is_lshift)      lshift_d = 1'b1;
            else if (is_rshift) rshift_d = 1'b1;
            else if (!(SUPPRESS_REPEAT && held_valid_q && held_key_q == key_id)) begin
                push         = 1'b1;
                held_valid_d = 1'b1;
                held_key_d   = key_id;
            end
        end else if (ev_break) begin
            if (is_lshift)      lshift_d = 1'b0;
            else if (is_rshift) rshift_d = 1'b0;
            else if (held_valid_q && held_key_q == key_id) held_valid_d = 1'b0;
        end
    end

    ps2_event_fifo #(
        .W          (KEY_WORD_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk        (Clock_50),
        .rst        (Reset),
        .clear_i    (bus.Clear_I),
        .push_i     (push),
        .pop_i      (bus.Key_pop_I),
        .data_i     ({lshift_q | rshift_q, key_id}),
        .data_o     (bus.Key_data_O),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .overflow_o (bus.Overflow_O)
    );

    assign bus.Key_count_O  = fifo_count;
    assign bus.Key_valid_O  = !fifo_empty;
    assign bus.Shift_O      = lshift_q | rshift_q;
    assign bus.parser_state = state_q;

    logic unused_full;
    assign unused_full = fifo_full;
endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Bench for ps2_key_event_queue: directed PS/2 byte sequences, a queue-based
// reference model compared every cycle, plus literal checks of key results.
module tb_ps2_key_event_queue;
    import ps2_key_pkg::*;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic run_cmp;

    ps2_key_event_queue_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

    ps2_key_event_queue #(
        .DEPTH_LOG2      (DEPTH_LOG2),
        .SUPPRESS_REPEAT (1'b1)
    ) dut (
        .Clock_50 (clk),
        .Reset    (rst),
        .bus      (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [9:0] m_q[$];
    logic       m_lshift, m_rshift, m_ovf;
    logic       m_ext_pend, m_brk_pend;
    int         m_held;   // -1 when no key is held, else {ext, code}

    task automatic model_reset();
        m_q.delete();
        m_lshift   = 1'b0;
        m_rshift   = 1'b0;
        m_ovf      = 1'b0;
        m_ext_pend = 1'b0;
        m_brk_pend = 1'b0;
        m_held     = -1;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic pop);
        logic       ext, brk, do_push, sh;
        logic [8:0] id;
        int         id_int;
        do_push = 1'b0;
        id      = '0;
        sh      = m_lshift | m_rshift;
        if (b == 8'h00 || b == 8'hFF || b == 8'hE1) begin
            m_ext_pend = 1'b0;
            m_brk_pend = 1'b0;
        end else if (b == 8'hE0 && !m_ext_pend && !m_brk_pend) begin
            m_ext_pend = 1'b1;
        end else if (b == 8'hF0 && !m_brk_pend) begin
            m_brk_pend = 1'b1;
        end else begin
            ext = m_ext_pend;
            brk = m_brk_pend;
            m_ext_pend = 1'b0;
            m_brk_pend = 1'b0;
            id     = {ext, b};
            id_int = int'(id);
            if (!ext && b == 8'h12)      m_lshift = !brk;
            else if (!ext && b == 8'h59) m_rshift = !brk;
            else if (brk) begin
                if (m_held == id_int) m_held = -1;
            end else if (m_held != id_int) begin
                do_push = 1'b1;
                m_held  = id_int;
            end
        end
        if (pop && m_q.size() > 0) void'(m_q.pop_front());
        if (do_push) begin
            if (m_q.size() < DEPTH) m_q.push_back({sh, id});
            else                    m_ovf = 1'b1;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            check("valid", 32'(bus.Key_valid_O), 32'(m_q.size() > 0));
            check("data", 32'(bus.Key_data_O), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
            check("count", 32'(bus.Key_count_O), 32'(m_q.size()));
            check("shift", 32'(bus.Shift_O), 32'(m_lshift | m_rshift));
            check("overflow", 32'(bus.Overflow_O), 32'(m_ovf));
        end
    end

    // ---------------- driver tasks ----------------
    // All drivers start and end at posedge+1, so the model updates right
    // after the edge that registers the DUT's response.
    task automatic send_byte(input logic [7:0] b, input logic pop = 1'b0);
        bus.PS2_code       = b;
        bus.PS2_code_ready = 1'b1;
        bus.Key_pop_I      = pop;
        @(posedge clk); #1;
        model_byte(b, pop);
        bus.Key_pop_I = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.PS2_code_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pop_key();
        bus.Key_pop_I = 1'b1;
        @(posedge clk); #1;
        if (m_q.size() > 0) void'(m_q.pop_front());
        bus.Key_pop_I = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.Clear_I = 1'b1;
        @(posedge clk); #1;
        m_q.delete();
        m_ovf = 1'b0;
        bus.Clear_I = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rep_seq [0:7];
        logic [7:0] ext_seq [0:7];
        checks = 0;
        errors = 0;
        run_cmp = 1'b0;
        bus.PS2_code       = 8'h00;
        bus.PS2_code_ready = 1'b0;
        bus.Clear_I        = 1'b0;
        bus.Key_pop_I      = 1'b0;
        rst = 1'b1;
        model_reset();
        run_cmp = 1'b1;
        @(posedge clk); #1;
        check("reset_count", 32'(bus.Key_count_O), 32'd0);
        check("reset_state", 32'(bus.parser_state), 32'(S_IDLE));
        apply_reset();

        // simple make / break
        send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
        check("mb_count", 32'(bus.Key_count_O), 32'd1);
        check("mb_data", 32'(bus.Key_data_O), 32'h01C);
        pop_key();

        // extended key with shift held
        ext_seq = '{8'h12, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hF0, 8'h12};
        for (int i = 0; i < 8; i++) begin
            send_byte(ext_seq[i]);
            if (i == 0) check("shift_set", 32'(bus.Shift_O), 32'd1);
        end
        check("ext_count", 32'(bus.Key_count_O), 32'd1);
        check("ext_data", 32'(bus.Key_data_O), 32'h375);
        check("shift_clr", 32'(bus.Shift_O), 32'd0);
        pop_key();

        // typematic repeat
        rep_seq = '{8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
        for (int i = 0; i < 8; i++) send_byte(rep_seq[i]);
        check("rep_count", 32'(bus.Key_count_O), 32'd2);
        check("rep_data0", 32'(bus.Key_data_O), 32'h01C);
        pop_key();
        check("rep_data1", 32'(bus.Key_data_O), 32'h01C);
        pop_key();
        send_byte(8'hF0); send_byte(8'h1C);

        // overflow: 17 distinct makes, breaks between
        for (int i = 0; i < 17; i++) begin
            send_byte(8'h30 + 8'(i));
            send_byte(8'hF0);
            send_byte(8'h30 + 8'(i));
        end
        check("ovf_count", 32'(bus.Key_count_O), 32'd16);
        check("ovf_flag", 32'(bus.Overflow_O), 32'd1);
        check("ovf_head", 32'(bus.Key_data_O), 32'h030);

        // push and pop together while full
        send_byte(8'h50, 1'b1);
        check("pp_count", 32'(bus.Key_count_O), 32'd16);
        check("pp_head", 32'(bus.Key_data_O), 32'h031);
        for (int i = 0; i < 14; i++) pop_key();
        check("tail_prev", 32'(bus.Key_data_O), 32'h03F);
        pop_key();
        check("tail_last", 32'(bus.Key_data_O), 32'h050);
        pulse_clear();
        check("clr_count", 32'(bus.Key_count_O), 32'd0);
        check("clr_ovf", 32'(bus.Overflow_O), 32'd0);

        // reset in the middle of an extended break sequence
        send_byte(8'hE0); send_byte(8'hF0);
        check("mid_state", 32'(bus.parser_state), 32'(S_EXT_BREAK));
        apply_reset();
        send_byte(8'h1C);
        check("rst_count", 32'(bus.Key_count_O), 32'd1);
        check("rst_data", 32'(bus.Key_data_O), 32'h01C);

        // junk byte aborts a pending prefix
        send_byte(8'hE0); send_byte(8'hE1); send_byte(8'h2A);
        check("junk_data", 32'(bus.Key_data_O), 32'h01C);
        pop_key();
        check("junk_next", 32'(bus.Key_data_O), 32'h02A);

        repeat (3) @(posedge clk);
        run_cmp = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_key_event_queue.md
# ps2_key_event_queue

Upstream neighbour of the PS/2-to-LCD character path: it takes the raw scan-code byte stream from `PS2_controller` and strips prefix and break bytes. It tracks shift state and suppresses typematic auto-repeat. Surviving key presses go into a small show-ahead FIFO that the LCD-side state machine pops at its own pace, so keystrokes typed during a 16-character LCD refresh are not lost.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth = 2^DEPTH_LOG2 entries (16).
- `SUPPRESS_REPEAT`, default 1: when 1, auto-repeat make codes of a held key are dropped.

Ports:
- `Clock_50`, input, 1: 50 MHz system clock. All logic runs in this one clock domain.
- `Reset`, input, 1: asynchronous, active-high reset.
- `PS2_code`, input, 8: last received scan byte. Valid whenever `PS2_code_ready` is high.
- `PS2_code_ready`, input, 1: level from `PS2_controller`. Each new byte is marked by a rising edge.
- `Clear_I`, input, 1: synchronous one-cycle pulse. It empties the FIFO and clears the overflow flag. It does not change parser or shift state.
- `Key_pop_I`, input, 1: consumer pulse that removes the head entry. Ignored when the FIFO is empty.
- `Key_valid_O`, output, 1: FIFO not empty.
- `Key_data_O`, output, 10: head entry, packed as {shift, extended, code[7:0]}. Forced to 0 when the FIFO is empty.
- `Key_count_O`, output, DEPTH_LOG2+1: current occupancy, 0..2^DEPTH_LOG2.
- `Shift_O`, output, 1: 1 while left shift (0x12) or right shift (0x59) is held.
- `Overflow_O`, output, 1: sticky flag. Set when a push is dropped because the FIFO is full.

## Operation
- **Byte strobe.** A registered copy of `PS2_code_ready` is kept. The strobe is `PS2_code_ready & ~buf`. Exactly one strobe occurs per byte.
- **Parser FSM.** States are S_IDLE, S_EXT, S_BREAK and S_EXT_BREAK. All transitions happen only on a strobe.
  - In S_IDLE: 0xE0 moves to S_EXT. 0xF0 moves to S_BREAK. Any other byte is a make code with extended=0.
  - In S_EXT: 0xF0 moves to S_EXT_BREAK. Any other byte is a make code with extended=1, and the FSM returns to S_IDLE.
  - In S_BREAK: the byte is a break code with extended=0, and the FSM returns to S_IDLE.
  - In S_EXT_BREAK: the byte is a break code with extended=1, and the FSM returns to S_IDLE.
  - Bytes 0x00, 0xFF and 0xE1 in any state are dropped, and the FSM returns to S_IDLE.
- **Shift tracking.** Applies only to non-extended codes.
  - A make code of 0x12 sets the left-shift bit; its break code clears it. Right shift (0x59) uses its own bit the same way.
  - Shift make and break codes are never pushed.
- **Repeat suppression.** The block keeps a held register {valid, extended, code}.
  - A make code equal to held.valid && {extended, code} is dropped.
  - Any other non-shift make code is pushed, and held is updated to that key.
  - A break code matching the held key clears held.valid.
  - Break codes are never pushed.
- **Pushed word.** {Shift_O value before this byte, extended, code}.
- **FIFO behaviour.** The FIFO is show-ahead: `Key_data_O` reads mem[rd_ptr] combinationally.
  - Push while full with no pop: the push is dropped and `Overflow_O` is set to 1.
  - Push and pop together when full: both take effect, and the count stays at the maximum.
  - Push and pop together when empty: the pop is ignored and the push is accepted.
  - Pointers are DEPTH_LOG2 bits wide and wrap modulo the depth.
- **Clear_I and push in the same cycle.** Clear wins and the push is lost.

## Timing
- **Reset.** All outputs are 0, the parser is in S_IDLE, held.valid=0, pointers are 0 and buf=0. Reset can be asserted mid-byte-sequence; the parser restarts in S_IDLE with no partial push.
- **Strobe latency.** A strobe in cycle T is decoded in T, and the FIFO write lands at the T→T+1 edge.
  - `Key_valid_O`, `Key_data_O` and `Key_count_O` reflect the push from cycle T+1.
  - `Shift_O` updates at T+1.
- **Pop.** A pop in cycle P advances the head at the P→P+1 edge. The next entry, or 0 if the FIFO is now empty, appears in P+1.
- **Throughput.** One push and one pop per cycle maximum. PS/2 byte spacing is 1 ms or more, so input back-pressure is not needed.

## Structure
- **Package `ps2_key_pkg`:**
  - parser state enum;
  - constants PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BREAK=8'hF0, PS2_PAUSE=8'hE1, PS2_LSHIFT=8'h12, PS2_RSHIFT=8'h59;
  - key-word packing widths.
- **Sub-module `ps2_event_fifo`:** a parameterised synchronous show-ahead FIFO with push, pop, clear, count, full and empty.
- **Top block:** the strobe detector, parser FSM, shift register bits and repeat filter.

## Test plan
- **Simple make/break.** Send bytes 1C, F0, 1C. Required: exactly one entry, 0x01C; `Key_count_O`=1.
- **Extended key and shift.** Send 12, E0, 75, E0, F0, 75, F0, 12. Required:
  - one entry, 0x375;
  - `Shift_O`=1 after the first byte and 0 after the last.
- **Typematic repeat.** Send 1C ×5, then F0 1C, then 1C. Required: two entries, 0x01C and 0x01C.
- **Overflow.** Push 17 distinct make codes (with breaks in between) and no pops. Required:
  - count=16;
  - `Overflow_O`=1;
  - head is the first code;
  - the 17th code is absent.
  - Then pulse `Clear_I`: count=0 and `Overflow_O`=0.
- **Simultaneous push/pop.** With the FIFO full, pop in the same cycle as a strobe. Required: count stays at 16, and the head advances to the second entry.
- **Reset mid-sequence.** Send E0 F0, assert `Reset`, then send 1C. Required: entry 0x01C (make, not a break).
